// File: rtl/itag_bist_ctrl.sv
// March C- BIST controller for the instruction tag RAM, with a write-only zero-fill mode.
// Latency: op k is driven after edge k from start; compare result lands two edges after its read.
// No backpressure: one array operation per cycle; test_mode=0 aborts a run immediately.
module itag_bist_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              bist_reset,
  input  logic              test_mode,
  input  logic [1:0]        bist_mode,
  input  logic [DATA_W-1:0] tag_rd_data,
  output logic [ADDR_W-1:0] bist_adr,
  output logic              bist_we,
  output logic [DATA_W-1:0] bist_pattern,
  output logic              bist_on,
  output logic              done,
  output logic              error_l,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [2:0]        fail_elem
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_CHK  = 2'b10;
  localparam logic [1:0] M_FILL = 2'b11;

  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  // Checkerboard base word: 0101... with bit0 set.
  function automatic logic [DATA_W-1:0] f_chk_base();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [DATA_W-1:0] CHK_BASE = f_chk_base();

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [2:0]        r_elem;     // element of the next operation to issue
  logic [ADDR_W-1:0] r_adr;      // address of the next operation to issue
  logic              r_ph;       // 0: next op is the read, 1: next op is the write
  logic              r_fin;      // last operation has been issued
  logic              r_rd;       // operation on the outputs this cycle is a read
  logic [DATA_W-1:0] r_rd_exp;
  logic [2:0]        r_rd_elem;
  logic              r_cmp_vld;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_adr;
  logic [2:0]        r_cmp_elem;

  logic              w_start;
  logic              w_fill;
  logic              w_down;
  logic              w_wval;
  logic              w_rval;
  logic [DATA_W-1:0] w_bg;
  logic [DATA_W-1:0] w_wpat;
  logic [DATA_W-1:0] w_rexp;
  logic              w_adr_last;
  logic              w_elem_last;
  logic              w_adr_done;
  logic              w_miss;

  // Next-operation decode from the sequence counters.
  always_comb begin
    w_start     = (r_state == S_IDLE) && test_mode && (bist_mode != 2'b00);
    w_fill      = (r_mode == M_FILL);
    w_down      = (r_elem >= 3'd3);
    w_wval      = (r_elem == 3'd1) || (r_elem == 3'd3);
    w_rval      = (r_elem == 3'd2) || (r_elem == 3'd4);
    w_bg        = (r_mode == M_CHK) ? (CHK_BASE ^ {DATA_W{r_adr[0]}}) : '0;
    w_wpat      = w_fill ? '0 : (w_bg ^ {DATA_W{w_wval}});
    w_rexp      = w_bg ^ {DATA_W{w_rval}};
    w_adr_last  = w_down ? (r_adr == '0) : (r_adr == {ADDR_W{1'b1}});
    w_elem_last = w_fill || (r_elem == 3'd5);
    // A write, or the lone read of M5, finishes work on the current address.
    w_adr_done  = r_ph || (r_elem == 3'd5);
    w_miss      = r_cmp_vld && (tag_rd_data != r_cmp_exp);
  end

  // Control FSM: start, issue one operation per cycle, flush, done, abort.
  always_ff @(posedge clk or posedge bist_reset) begin
    if (bist_reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'b00;
      r_elem       <= 3'd0;
      r_adr        <= '0;
      r_ph         <= 1'b0;
      r_fin        <= 1'b0;
      r_rd         <= 1'b0;
      r_rd_exp     <= '0;
      r_rd_elem    <= 3'd0;
      bist_adr     <= '0;
      bist_we      <= 1'b0;
      bist_pattern <= '0;
      bist_on      <= 1'b0;
      done         <= 1'b0;
    end else begin
      bist_we <= 1'b0;
      r_rd    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_mode  <= bist_mode;
            r_elem  <= 3'd0;
            r_adr   <= '0;
            r_ph    <= 1'b1;
            r_fin   <= 1'b0;
            bist_on <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!test_mode) begin
            r_state <= S_IDLE;
            bist_on <= 1'b0;
          end else if (r_fin) begin
            r_state <= S_FLUSH;
          end else begin
            bist_adr     <= r_adr;
            bist_we      <= r_ph;
            bist_pattern <= w_wpat;
            r_rd         <= ~r_ph;
            r_rd_exp     <= w_rexp;
            r_rd_elem    <= r_elem;
            if (!w_adr_done) begin
              r_ph <= 1'b1;
            end else if (!w_adr_last) begin
              r_adr <= w_down ? (r_adr - ADR_ONE) : (r_adr + ADR_ONE);
              r_ph  <= (r_elem == 3'd0);
            end else if (w_elem_last) begin
              r_fin <= 1'b1;
            end else begin
              r_elem <= r_elem + 3'd1;
              r_adr  <= (r_elem >= 3'd2) ? {ADDR_W{1'b1}} : '0;
              r_ph   <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          r_state <= test_mode ? S_DONE : S_IDLE;
          bist_on <= 1'b0;
          done    <= test_mode;
        end
        default: begin
          if (!test_mode || (bist_mode == 2'b00)) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Readback compare pipeline and sticky first-failure capture.
  always_ff @(posedge clk or posedge bist_reset) begin
    if (bist_reset) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_adr  <= '0;
      r_cmp_elem <= 3'd0;
      error_l    <= 1'b1;
      fail_adr   <= '0;
      fail_elem  <= 3'd0;
    end else begin
      r_cmp_vld  <= r_rd;
      r_cmp_exp  <= r_rd_exp;
      r_cmp_adr  <= bist_adr;
      r_cmp_elem <= r_rd_elem;
      if (w_start) begin
        error_l   <= 1'b1;
        fail_adr  <= '0;
        fail_elem <= 3'd0;
      end else if (w_miss) begin
        error_l <= 1'b0;
        if (error_l) begin
          fail_adr  <= r_cmp_adr;
          fail_elem <= r_cmp_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_itag_bist_ctrl.sv
// Bench for itag_bist_ctrl with a 4-word, 4-bit behavioural tag array.
// Expected operation traces and completion/error events are queued up front.
// A negedge monitor pops and compares whenever the controller drives the array or flags an event.
module tb_itag_bist_ctrl;
  localparam int AW = 2;
  localparam int DW = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] pat;
    logic          care_adr;
    logic          care_pat;
  } op_t;

  typedef struct packed {
    logic [31:0]   e;
    logic          err;
    logic [AW-1:0] fa;
    logic [2:0]    fe;
  } ev_t;

  logic          clk = 1'b0;
  logic          bist_reset;
  logic          test_mode;
  logic [1:0]    bist_mode;
  logic [DW-1:0] tag_rd_data;
  logic [AW-1:0] bist_adr;
  logic          bist_we;
  logic [DW-1:0] bist_pattern;
  logic          bist_on;
  logic          done;
  logic          error_l;
  logic [AW-1:0] fail_adr;
  logic [2:0]    fail_elem;

  itag_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .bist_reset(bist_reset), .test_mode(test_mode), .bist_mode(bist_mode),
    .tag_rd_data(tag_rd_data), .bist_adr(bist_adr), .bist_we(bist_we),
    .bist_pattern(bist_pattern), .bist_on(bist_on), .done(done), .error_l(error_l),
    .fail_adr(fail_adr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // Behavioural array: registers address/data on the edge, read data valid the cycle after.
  logic [DW-1:0] mem [4];
  logic [DW-1:0] rd_q;
  logic          stuck;
  always @(posedge clk) begin
    rd_q <= mem[bist_adr];
    if (bist_we) mem[bist_adr] <= bist_pattern | ((stuck && bist_adr == 2'd2) ? 4'b0001 : 4'b0000);
  end
  assign tag_rd_data = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  op_t trace_q[$];
  op_t gen_q[$];
  ev_t done_q[$];
  ev_t err_q[$];
  int  total = 0;
  int  bad = 0;
  int  start_e = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic we, input int a, input logic [3:0] p, input logic ca, input logic cp);
    op_t o;
    o.we = we; o.adr = AW'(a); o.pat = p; o.care_adr = ca; o.care_pat = cp;
    return o;
  endfunction

  function automatic ev_t mk_ev(input int e, input logic err, input int fa, input int fe);
    ev_t v;
    v.e = 32'(e); v.err = err; v.fa = AW'(fa); v.fe = 3'(fe);
    return v;
  endfunction

  function automatic logic [3:0] bg(input logic [1:0] m, input int a);
    if (m != 2'b10) return 4'b0000;
    return (a % 2 == 1) ? 4'b1010 : 4'b0101;
  endfunction

  // March C-: M0 up w0, M1 up r0w1, M2 up r1w0, M3 down r0w1, M4 down r1w0, M5 down r0.
  task automatic gen_march(input logic [1:0] m);
    gen_q.delete();
    gen_q.push_back(mk(1'b0, 0, 4'h0, 1'b0, 1'b0));
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 4; i++) begin
        int a;
        logic [3:0] p;
        a = (e >= 3) ? 3 - i : i;
        p = bg(m, a) ^ (((e == 1) || (e == 3)) ? 4'hF : 4'h0);
        if (e >= 1) gen_q.push_back(mk(1'b0, a, p, 1'b1, e <= 4));
        if (e <= 4) gen_q.push_back(mk(1'b1, a, p, 1'b1, 1'b1));
      end
    end
    gen_q.push_back(mk(1'b0, 0, 4'h0, 1'b0, 1'b0));
  endtask

  task automatic gen_fill();
    gen_q.delete();
    gen_q.push_back(mk(1'b0, 0, 4'h0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) gen_q.push_back(mk(1'b1, i, 4'h0, 1'b1, 1'b1));
    gen_q.push_back(mk(1'b0, 0, 4'h0, 1'b0, 1'b0));
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n && i < gen_q.size(); i++) trace_q.push_back(gen_q[i]);
  endtask

  // Called at a negedge: the following posedge is edge 0 of the run.
  task automatic go(input logic [1:0] m);
    test_mode = 1'b1;
    bist_mode = m;
    start_e   = cyc + 1;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: done never rose within 120 cycles", nm);
    end
    chk({nm, "_ops_left"}, trace_q.size(), 0);
    chk({nm, "_done_ev_left"}, done_q.size(), 0);
    chk({nm, "_err_ev_left"}, err_q.size(), 0);
    trace_q.delete(); done_q.delete(); err_q.delete();
  endtask

  task automatic to_idle();
    bist_mode = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_adr"}, bist_adr, 0);
    chk({nm, "_we"}, bist_we, 0);
    chk({nm, "_pat"}, bist_pattern, 0);
    chk({nm, "_on"}, bist_on, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error_l"}, error_l, 1);
    chk({nm, "_fail_adr"}, fail_adr, 0);
    chk({nm, "_fail_elem"}, fail_elem, 0);
  endtask

  // Monitor: array operations while bist_on, plus done-rise and error_l-fall events.
  logic prev_done = 1'b0;
  logic prev_err  = 1'b1;
  op_t  mon_o;
  ev_t  mon_v;
  always @(negedge clk) begin
    if (bist_reset) begin
      prev_done = 1'b0;
      prev_err  = 1'b1;
    end else begin
      if (bist_on) begin
        total++;
        if (trace_q.size() == 0) begin
          bad++;
          $display("FAIL op_unexpected: cyc=%0d adr=%0d we=%0b with no op expected", cyc, bist_adr, bist_we);
        end else begin
          mon_o = trace_q.pop_front();
          if (bist_we !== mon_o.we || (mon_o.care_adr && bist_adr !== mon_o.adr) ||
              (mon_o.care_pat && bist_pattern !== mon_o.pat)) begin
            bad++;
            $display("FAIL op cyc=%0d: got we=%0b adr=%0d pat=%b expected we=%0b adr=%0d pat=%b",
                     cyc, bist_we, bist_adr, bist_pattern, mon_o.we, mon_o.adr, mon_o.pat);
          end
        end
      end
      if (done && !prev_done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: done rose at cyc=%0d", cyc);
        end else begin
          mon_v = done_q.pop_front();
          if (32'(cyc) !== mon_v.e || error_l !== mon_v.err || fail_adr !== mon_v.fa || fail_elem !== mon_v.fe) begin
            bad++;
            $display("FAIL done_event: got edge=%0d error_l=%0b fail_adr=%0d fail_elem=%0d expected edge=%0d error_l=%0b fail_adr=%0d fail_elem=%0d",
                     cyc, error_l, fail_adr, fail_elem, mon_v.e, mon_v.err, mon_v.fa, mon_v.fe);
          end
        end
      end
      if (!error_l && prev_err) begin
        total++;
        if (err_q.size() == 0) begin
          bad++;
          $display("FAIL error_unexpected: error_l fell at cyc=%0d adr=%0d elem=%0d", cyc, fail_adr, fail_elem);
        end else begin
          mon_v = err_q.pop_front();
          if (32'(cyc) !== mon_v.e || fail_adr !== mon_v.fa || fail_elem !== mon_v.fe) begin
            bad++;
            $display("FAIL error_event: got edge=%0d fail_adr=%0d fail_elem=%0d expected edge=%0d fail_adr=%0d fail_elem=%0d",
                     cyc, fail_adr, fail_elem, mon_v.e, mon_v.fa, mon_v.fe);
          end
        end
      end
      prev_done = done;
      prev_err  = error_l;
    end
  end

  initial begin
    bist_reset = 1'b1;
    test_mode  = 1'b0;
    bist_mode  = 2'b00;
    stuck      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    bist_reset = 1'b0;
    @(negedge clk);

    // Solid March C-, fault-free.
    gen_march(2'b01); load(1000); go(2'b01);
    done_q.push_back(mk_ev(start_e + 42, 1'b1, 0, 0));
    wait_done("solid");
    to_idle();

    // Solid March C-, word 2 bit0 stuck at 1: first miss is the M1 read of adr 2.
    stuck = 1'b1;
    gen_march(2'b01); load(1000); go(2'b01);
    err_q.push_back(mk_ev(start_e + 11, 1'b0, 2, 1));
    done_q.push_back(mk_ev(start_e + 42, 1'b0, 2, 1));
    wait_done("stuck");

    // Mid-cycle async reset out of DONE with error captured.
    @(posedge clk);
    #2 bist_reset = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    bist_reset = 1'b0;
    stuck      = 1'b0;
    test_mode  = 1'b0;
    bist_mode  = 2'b00;
    @(negedge clk);

    // Checkerboard March C-, fault-free.
    gen_march(2'b10); load(1000); go(2'b10);
    done_q.push_back(mk_ev(start_e + 42, 1'b1, 0, 0));
    wait_done("chk");
    to_idle();

    // Zero-fill.
    gen_fill(); load(1000); go(2'b11);
    done_q.push_back(mk_ev(start_e + 6, 1'b1, 0, 0));
    wait_done("fill");
    for (int i = 0; i < 4; i++) chk($sformatf("fill_mem%0d", i), mem[i], 0);
    to_idle();

    // Abort at edge 15 of a solid run.
    gen_march(2'b01); load(15); go(2'b01);
    repeat (15) @(negedge clk);
    test_mode = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_on", bist_on, 0);
    chk("abort_we", bist_we, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_done_later", done, 0);
    chk("abort_ops_left", trace_q.size(), 0);
    trace_q.delete();

    // Restart; a mid-run mode change must be ignored.
    gen_march(2'b01); load(1000); go(2'b01);
    done_q.push_back(mk_ev(start_e + 42, 1'b1, 0, 0));
    repeat (20) @(negedge clk);
    bist_mode = 2'b10;
    wait_done("restart");
    to_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
